cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller_pkg.sv | 39 +++
 rtl/cache_way_array.sv | 41 ++++
 rtl/cache_controller.sv | 160 ++++++++++++++++
 tb/tb_cache_controller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_controller_pkg.sv
// Shared geometry, address-field positions and FSM encoding for the
// 2-way set-associative write-through data cache.
package cache_controller_pkg;

  localparam int SETS    = 64;
  localparam int INDEX_W = 6;
  localparam int TAG_W   = 10;
  localparam int BLOCK_W = 64;
  localparam int WORD_W  = 32;

  localparam int WSEL_BIT  = 2;
  localparam int INDEX_LSB = 3;
  localparam int INDEX_MSB = 8;
  localparam int TAG_LSB   = 9;
  localparam int TAG_MSB   = 18;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_MISS = 2'd1;
  localparam logic [1:0] ST_WR_THRU = 2'd2;

  typedef struct packed {
    logic               valid;
    logic [TAG_W-1:0]   tag;
    logic [BLOCK_W-1:0] data;
  } way_rd_t;

  // Block layout is {word1, word0}; sel is address bit 2.
  function automatic logic [WORD_W-1:0] get_word(input logic [BLOCK_W-1:0] blk,
                                                 input logic sel);
    get_word = sel ? blk[BLOCK_W-1:WORD_W] : blk[WORD_W-1:0];
  endfunction

  function automatic logic [BLOCK_W-1:0] put_word(input logic [BLOCK_W-1:0] blk,
                                                  input logic sel,
                                                  input logic [WORD_W-1:0] w);
    put_word = sel ? {w, blk[WORD_W-1:0]} : {blk[BLOCK_W-1:WORD_W], w};
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// One cache way: valid/tag/data storage, combinational read port, one write port.
// Only the valid bits are reset; tag and data contents are don't-care until filled.
module cache_way_array
  import cache_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index_i,
  output way_rd_t            rd_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [BLOCK_W-1:0] wr_data_i
);

  logic [SETS-1:0]    valid_q;
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [BLOCK_W-1:0] data_q [SETS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_o.valid = valid_q[rd_index_i];
    rd_o.tag   = tag_q[rd_index_i];
    rd_o.data  = data_q[rd_index_i];
  end

endmodule

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate 2-way data cache between the MEM stage and
// the SRAM controller: FSM, hit detection, per-set LRU and SRAM-side muxing.
module cache_controller
  import cache_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic               sram_rd_en,
  output logic               sram_wr_en,
  output logic [31:0]        sram_address,
  output logic [31:0]        sram_wdata,
  input  logic [BLOCK_W-1:0] sram_rdata,
  input  logic               sram_ready,
  output logic [1:0]         dbg_state
);

  // Handshake: a request (rd_en/wr_en) completes in the cycle ready=1; while
  // ready=0 the pipeline holds address/wdata stable. Towards the SRAM, an
  // enable stays high until the single-cycle sram_ready pulse ends the access.

  logic [1:0]         state_q, state_d;
  logic [SETS-1:0]    lru_q;
  logic               lru_we;
  logic               lru_val;

  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               wsel;
  way_rd_t            way0, way1;
  logic               hit0, hit1, victim;
  logic [BLOCK_W-1:0] hit_block, fill_data;
  logic               we0, we1;

  assign index = address[INDEX_MSB:INDEX_LSB];
  assign tag   = address[TAG_MSB:TAG_LSB];
  assign wsel  = address[WSEL_BIT];

  cache_way_array u_way0 (
    .clk        (clk),
    .rst        (rst),
    .rd_index_i (index),
    .rd_o       (way0),
    .wr_en_i    (we0),
    .wr_index_i (index),
    .wr_tag_i   (tag),
    .wr_data_i  (fill_data)
  );

  cache_way_array u_way1 (
    .clk        (clk),
    .rst        (rst),
    .rd_index_i (index),
    .rd_o       (way1),
    .wr_en_i    (we1),
    .wr_index_i (index),
    .wr_tag_i   (tag),
    .wr_data_i  (fill_data)
  );

  assign hit0      = way0.valid && (way0.tag == tag);
  assign hit1      = way1.valid && (way1.tag == tag);
  assign hit_block = hit1 ? way1.data : way0.data;
  // LRU bit names the way to replace next, so an access to way w stores ~w.
  assign victim    = !way0.valid ? 1'b0 : (!way1.valid ? 1'b1 : lru_q[index]);
  assign dbg_state = state_q;

  always_comb begin
    state_d      = state_q;
    ready        = 1'b1;
    rdata        = '0;
    sram_rd_en   = 1'b0;
    sram_wr_en   = 1'b0;
    sram_address = '0;
    sram_wdata   = '0;
    we0          = 1'b0;
    we1          = 1'b0;
    fill_data    = hit_block;
    lru_we       = 1'b0;
    lru_val      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_en) begin
          ready   = 1'b0;
          state_d = ST_WR_THRU;
          if (hit0 || hit1) begin
            we0       = hit0;
            we1       = hit1;
            fill_data = put_word(hit_block, wsel, wdata);
            lru_we    = 1'b1;
            lru_val   = hit0;
          end
        end else if (rd_en) begin
          if (hit0 || hit1) begin
            rdata   = get_word(hit_block, wsel);
            lru_we  = 1'b1;
            lru_val = hit0;
          end else begin
            ready   = 1'b0;
            state_d = ST_RD_MISS;
          end
        end
      end
      ST_RD_MISS: begin
        ready        = 1'b0;
        sram_rd_en   = 1'b1;
        sram_address = {address[31:INDEX_LSB], {INDEX_LSB{1'b0}}};
        if (sram_ready) begin
          ready     = 1'b1;
          rdata     = get_word(sram_rdata, wsel);
          fill_data = sram_rdata;
          we0       = ~victim;
          we1       = victim;
          lru_we    = 1'b1;
          lru_val   = ~victim;
          state_d   = ST_IDLE;
        end
      end
      ST_WR_THRU: begin
        ready        = 1'b0;
        sram_wr_en   = 1'b1;
        sram_address = address;
        sram_wdata   = wdata;
        if (sram_ready) begin
          ready   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset aborts any transaction: no SRAM traffic, no array or LRU update.
    if (!rst) begin
      state_d    = ST_IDLE;
      ready      = 1'b1;
      sram_rd_en = 1'b0;
      sram_wr_en = 1'b0;
      we0        = 1'b0;
      we1        = 1'b0;
      lru_we     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      if (lru_we) begin
        lru_q[index] <= lru_val;
      end
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: hand-computed vectors driven through a
// transaction task, with an SRAM response pulse at a chosen cycle.
module tb_cache_controller;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;
  logic [1:0]  dbg_state;

  int          n_checks = 0;
  int          n_bad    = 0;
  logic [31:0] exp_q[$];

  int          r_cycles;
  int          r_rd_cnt;
  int          r_wr_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  cache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .rd_en        (rd_en),
    .wr_en        (wr_en),
    .address      (address),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .sram_rd_en   (sram_rd_en),
    .sram_wr_en   (sram_wr_en),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready),
    .dbg_state    (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives one request; sram_ready pulses in cycle 'lat' (cycle 0 = request
  // cycle). Records the cycle ready rose and the SRAM-side activity seen.
  task automatic xact(input logic wr, input logic rd, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [63:0] blk, input int lat);
    rd_en      = rd;
    wr_en      = wr;
    address    = addr;
    wdata      = wd;
    sram_rdata = blk;
    r_cycles   = -1;
    r_rd_cnt   = 0;
    r_wr_cnt   = 0;
    r_addr     = '0;
    r_wdata    = '0;
    r_rdata    = '0;
    for (int c = 0; c < 64; c++) begin
      sram_ready = (c == lat);
      @(negedge clk);
      if (sram_rd_en) begin
        r_rd_cnt++;
        r_addr = sram_address;
      end
      if (sram_wr_en) begin
        r_wr_cnt++;
        r_addr  = sram_address;
        r_wdata = sram_wdata;
      end
      if (ready) begin
        r_cycles = c;
        r_rdata  = rdata;
      end
      @(posedge clk);
      #1;
      if (r_cycles >= 0) break;
    end
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    sram_ready = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [31:0] addr, input logic [63:0] blk,
                         input int lat, input int exp_cycles, input logic [31:0] exp_data);
    exp_q.push_back(exp_data);
    xact(1'b0, 1'b1, addr, 32'h0, blk, lat);
    check_val({name, "_latency"}, r_cycles, exp_cycles);
    check_val({name, "_rdata"}, r_rdata, exp_q.pop_front());
    if (exp_cycles > 0) begin
      check_val({name, "_sram_rd_cycles"}, r_rd_cnt, lat);
      check_val({name, "_sram_addr"}, r_addr, {addr[31:3], 3'b000});
    end else begin
      check_val({name, "_no_sram_rd"}, r_rd_cnt, 0);
    end
  endtask

  task automatic do_write(input string name, input logic [31:0] addr, input logic [31:0] data,
                          input int lat, input logic also_rd);
    xact(1'b1, also_rd, addr, data, 64'h0, lat);
    check_val({name, "_latency"}, r_cycles, lat);
    check_val({name, "_sram_wr_cycles"}, r_wr_cnt, lat);
    check_val({name, "_no_sram_rd"}, r_rd_cnt, 0);
    check_val({name, "_sram_addr"}, r_addr, addr);
    check_val({name, "_sram_wdata"}, r_wdata, data);
  endtask

  initial begin
    rst        = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    address    = '0;
    wdata      = '0;
    sram_rdata = '0;
    sram_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("in_reset_ready", ready, 1);
    check_val("in_reset_sram_rd", sram_rd_en, 0);
    check_val("in_reset_sram_wr", sram_wr_en, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_val("idle_ready", ready, 1);
    check_val("idle_state", dbg_state, 0);
    check_val("idle_sram_rd", sram_rd_en, 0);
    check_val("idle_sram_wr", sram_wr_en, 0);
    @(posedge clk);
    #1;

    // Cold miss then same-line hit on the other word
    do_read("miss400", 32'h0000_0400, 64'h2222_2222_1111_1111, 5, 5, 32'h1111_1111);
    do_read("hit404", 32'h0000_0404, 64'h0, -1, 0, 32'h2222_2222);

    // Index 0 conflict set: 0x400 tag 2, 0x8400 tag 0x42, 0x10400 tag 0x82
    do_read("fill8400", 32'h0000_8400, 64'h4444_4444_3333_3333, 3, 3, 32'h3333_3333);
    do_read("hit400a", 32'h0000_0400, 64'h0, -1, 0, 32'h1111_1111);
    do_read("fill10400", 32'h0001_0400, 64'h6666_6666_5555_5555, 2, 2, 32'h5555_5555);
    do_read("hit400b", 32'h0000_0400, 64'h0, -1, 0, 32'h1111_1111);
    do_read("remiss8400", 32'h0000_8400, 64'h4444_4444_3333_3333, 4, 4, 32'h3333_3333);

    // Write hit updates the cached word; the other word is untouched
    do_write("wrhit400", 32'h0000_0400, 32'hDEAD_BEEF, 3, 1'b0);
    do_read("hit400_new", 32'h0000_0400, 64'h0, -1, 0, 32'hDEAD_BEEF);
    do_read("hit404_keep", 32'h0000_0404, 64'h0, -1, 0, 32'h2222_2222);

    // Write miss: no allocate, LRU still points at way1 (0x8400)
    do_write("wrmiss2000", 32'h0000_2000, 32'h0000_0005, 2, 1'b0);
    do_read("miss2000", 32'h0000_2000, 64'h0000_0007_0000_0005, 4, 4, 32'h0000_0005);
    do_read("hit400_after", 32'h0000_0400, 64'h0, -1, 0, 32'hDEAD_BEEF);
    do_read("hit2004", 32'h0000_2004, 64'h0, -1, 0, 32'h0000_0007);

    // Reset in the middle of a read miss, then a late sram_ready
    rd_en      = 1'b1;
    address    = 32'h0000_3008;
    sram_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
    sram_ready = 1'b0;
    @(negedge clk);
    check_val("abort_idle_ready", ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val("abort_miss_sram_rd", sram_rd_en, 1);
    check_val("abort_miss_state", dbg_state, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("abort_rst_ready", ready, 1);
    check_val("abort_rst_sram_rd", sram_rd_en, 0);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    rd_en      = 1'b0;
    sram_ready = 1'b1;
    @(negedge clk);
    check_val("abort_late_state", dbg_state, 0);
    check_val("abort_late_sram_rd", sram_rd_en, 0);
    @(posedge clk);
    #1 sram_ready = 1'b0;
    do_read("after_rst3008", 32'h0000_3008, 64'hBBBB_BBBB_CCCC_CCCC, 3, 3, 32'hCCCC_CCCC);
    do_read("after_rst400", 32'h0000_0400, 64'h2222_2222_1111_1111, 2, 2, 32'h1111_1111);

    // rd_en and wr_en together behave as a write
    do_write("rdwr400", 32'h0000_0400, 32'hCAFE_0001, 2, 1'b1);
    do_read("hit400_rdwr", 32'h0000_0400, 64'h0, -1, 0, 32'hCAFE_0001);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
